// File: rtl/debug_mem_ctrl.sv
// debug_mem_ctrl
//   Sequences the debug (second) ports of the instruction and data BRAMs.
//   A host issues load (host -> BRAM) or dump (BRAM -> host) commands. The
//   block then walks the BRAM one word at a time, wrapping past the top
//   word to index 0. The core is held in reset while a command is running.
//
// Ports
//   CPU_CLK, CPU_RST            clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         command handshake; cmd_ready is high in IDLE only
//   cmd_op, cmd_sel             0/1 = load/dump, 0/1 = DataCache/InstCache
//   cmd_base, cmd_count         first word index, word count (0 = BRAM_WORDS)
//   wr_valid/wr_ready/wr_data   load-data stream from the host
//   rd_valid/rd_ready/rd_data   dump-data stream to the host
//   busy, hold_core, done       activity flags, one-cycle end-of-command pulse
//   CPU_Debug_{Data,Inst}Cache_{A2,WD2,WE2,RD2}  BRAM debug ports
//
// State table
//   state    | meaning
//   IDLE     | waiting for a command, debug ports quiet
//   LD_WAIT  | load: waiting for the next host word
//   LD_WRITE | load: one-cycle write of the latched word
//   DP_ADDR  | dump: read address presented to the BRAM
//   DP_WAIT  | dump: BRAM read latency, RD2 captured on exit
//   DP_SEND  | dump: word offered to the host until accepted
//   DONE     | one-cycle done pulse before returning to IDLE

module debug_mem_ctrl #(
  parameter int BRAM_WORDS = 4096,
  parameter int IDX_W      = 12
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic              cmd_sel,
  input  logic [IDX_W-1:0]  cmd_base,
  input  logic [IDX_W:0]    cmd_count,

  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [31:0]       wr_data,

  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [31:0]       rd_data,

  output logic              busy,
  output logic              done,
  output logic              hold_core,

  output logic [31:0]       CPU_Debug_DataCache_A2,
  output logic [31:0]       CPU_Debug_DataCache_WD2,
  output logic [3:0]        CPU_Debug_DataCache_WE2,
  input  logic [31:0]       CPU_Debug_DataCache_RD2,

  output logic [31:0]       CPU_Debug_InstCache_A2,
  output logic [31:0]       CPU_Debug_InstCache_WD2,
  output logic [3:0]        CPU_Debug_InstCache_WE2,
  input  logic [31:0]       CPU_Debug_InstCache_RD2
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_WAIT  = 3'd1,
    LD_WRITE = 3'd2,
    DP_ADDR  = 3'd3,
    DP_WAIT  = 3'd4,
    DP_SEND  = 3'd5,
    DONE     = 3'd6
  } stateT;

  stateT              state;
  stateT              stateNext;

  logic               selReg;
  logic [IDX_W-1:0]   baseReg;
  logic [IDX_W:0]     countReg;
  // One bit wider than the index so a full-BRAM count can be reached.
  logic [IDX_W:0]     n;
  logic [IDX_W:0]     nInc;
  logic               lastWord;
  logic [IDX_W-1:0]   idx;
  logic [31:0]        wrDataReg;
  logic [31:0]        rdDataReg;

  logic [31:0]        portA2;
  logic [31:0]        portWD2;
  logic [3:0]         portWE2;

  assign nInc     = n + (IDX_W+1)'(1);
  assign lastWord = (nInc == countReg);
  // Index arithmetic is IDX_W bits wide, so it wraps modulo BRAM_WORDS.
  assign idx      = baseReg + n[IDX_W-1:0];

  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state     <= IDLE;
      selReg    <= 1'b0;
      baseReg   <= '0;
      countReg  <= '0;
      n         <= '0;
      wrDataReg <= '0;
      rdDataReg <= '0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            selReg   <= cmd_sel;
            baseReg  <= cmd_base;
            countReg <= (cmd_count == '0) ? (IDX_W+1)'(BRAM_WORDS) : cmd_count;
            n        <= '0;
          end
        end
        LD_WAIT: begin
          if (wr_valid) wrDataReg <= wr_data;
        end
        LD_WRITE: n <= nInc;
        DP_WAIT: rdDataReg <= selReg ? CPU_Debug_InstCache_RD2 : CPU_Debug_DataCache_RD2;
        DP_SEND: begin
          if (rd_ready) n <= nInc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:     if (cmd_valid) stateNext = cmd_op ? DP_ADDR : LD_WAIT;
      LD_WAIT:  if (wr_valid)  stateNext = LD_WRITE;
      LD_WRITE: stateNext = lastWord ? DONE : LD_WAIT;
      DP_ADDR:  stateNext = DP_WAIT;
      DP_WAIT:  stateNext = DP_SEND;
      DP_SEND:  if (rd_ready) stateNext = lastWord ? DONE : DP_ADDR;
      DONE:     stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // Port values are decoded from state and registers only; the address is
  // held through the whole transfer so a stalled dump keeps A2 steady.
  always_comb begin
    portA2  = '0;
    portWD2 = '0;
    portWE2 = '0;
    if (state inside {LD_WAIT, LD_WRITE, DP_ADDR, DP_WAIT, DP_SEND})
      portA2 = {{(30-IDX_W){1'b0}}, idx, 2'b00};
    if (state == LD_WRITE) begin
      portWD2 = wrDataReg;
      portWE2 = 4'b1111;
    end
  end

  assign CPU_Debug_DataCache_A2  = selReg ? '0 : portA2;
  assign CPU_Debug_DataCache_WD2 = selReg ? '0 : portWD2;
  assign CPU_Debug_DataCache_WE2 = selReg ? '0 : portWE2;
  assign CPU_Debug_InstCache_A2  = selReg ? portA2  : '0;
  assign CPU_Debug_InstCache_WD2 = selReg ? portWD2 : '0;
  assign CPU_Debug_InstCache_WE2 = selReg ? portWE2 : '0;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign hold_core = (state != IDLE);
  assign done      = (state == DONE);
  assign wr_ready  = (state == LD_WAIT);
  assign rd_valid  = (state == DP_SEND);
  assign rd_data   = rdDataReg;

endmodule

// File: tb/tb_debug_mem_ctrl.sv
module tb_debug_mem_ctrl;
  localparam int BRAM_WORDS = 4096;
  localparam int IDX_W      = 12;

  logic              CPU_CLK = 1'b0;
  logic              CPU_RST;
  logic              cmd_valid, cmd_ready, cmd_op, cmd_sel;
  logic [IDX_W-1:0]  cmd_base;
  logic [IDX_W:0]    cmd_count;
  logic              wr_valid, wr_ready;
  logic [31:0]       wr_data;
  logic              rd_valid, rd_ready;
  logic [31:0]       rd_data;
  logic              busy, done, hold_core;
  logic [31:0]       CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_RD2;
  logic [3:0]        CPU_Debug_DataCache_WE2;
  logic [31:0]       CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_RD2;
  logic [3:0]        CPU_Debug_InstCache_WE2;

  debug_mem_ctrl #(.BRAM_WORDS(BRAM_WORDS), .IDX_W(IDX_W)) dut (
    .CPU_CLK(CPU_CLK), .CPU_RST(CPU_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_sel(cmd_sel),
    .cmd_base(cmd_base), .cmd_count(cmd_count),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .hold_core(hold_core),
    .CPU_Debug_DataCache_A2(CPU_Debug_DataCache_A2), .CPU_Debug_DataCache_WD2(CPU_Debug_DataCache_WD2),
    .CPU_Debug_DataCache_WE2(CPU_Debug_DataCache_WE2), .CPU_Debug_DataCache_RD2(CPU_Debug_DataCache_RD2),
    .CPU_Debug_InstCache_A2(CPU_Debug_InstCache_A2), .CPU_Debug_InstCache_WD2(CPU_Debug_InstCache_WD2),
    .CPU_Debug_InstCache_WE2(CPU_Debug_InstCache_WE2), .CPU_Debug_InstCache_RD2(CPU_Debug_InstCache_RD2)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  // Synchronous-read BRAM models with byte enables.
  logic [31:0] dataMem [BRAM_WORDS];
  logic [31:0] instMem [BRAM_WORDS];
  always @(posedge CPU_CLK) begin
    for (int b = 0; b < 4; b++) begin
      if (CPU_Debug_DataCache_WE2[b])
        dataMem[CPU_Debug_DataCache_A2[13:2]][8*b +: 8] <= CPU_Debug_DataCache_WD2[8*b +: 8];
      if (CPU_Debug_InstCache_WE2[b])
        instMem[CPU_Debug_InstCache_A2[13:2]][8*b +: 8] <= CPU_Debug_InstCache_WD2[8*b +: 8];
    end
    CPU_Debug_DataCache_RD2 <= dataMem[CPU_Debug_DataCache_A2[13:2]];
    CPU_Debug_InstCache_RD2 <= instMem[CPU_Debug_InstCache_A2[13:2]];
  end

  // Scoreboard and bench-side reference contents.
  typedef struct packed {
    logic        sel;
    logic [31:0] addr;
    logic [31:0] data;
  } wrExpT;
  wrExpT       expWrQ[$];
  logic [31:0] expRdQ[$];
  logic [31:0] refData [BRAM_WORDS];
  logic [31:0] refInst [BRAM_WORDS];

  int checkCount = 0;
  int passCount  = 0;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Monitor state.
  int          cyc = 0;
  int          wrCyc[$];
  int          rdCyc[$];
  int          wrCount = 0, doneCount = 0, doneCyc = 0, acceptCyc = 0;
  int          otherPortHits = 0, stallViol = 0, stallCycles = 0, hcViol = 0, holdLow = 0;
  logic        selCur = 1'b0;
  logic        holdWindow = 1'b0;
  logic        prevStall = 1'b0;
  logic [31:0] prevRdData = '0, prevA2 = '0, lastWrAddr = '0;

  always @(posedge CPU_CLK) cyc <= cyc + 1;

  task automatic handleWrite(input logic sel, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    wrExpT e;
    wrCount++;
    lastWrAddr = a;
    wrCyc.push_back(cyc);
    if (expWrQ.size() == 0) begin
      checkVal("wr_unexpected", {sel, a}, 64'hFFFF_FFFF_FFFF_FFFF);
    end else begin
      e = expWrQ.pop_front();
      checkVal("wr_addr", {sel, a}, {e.sel, e.addr});
      checkVal("wr_data", {we, wd}, {4'hF, e.data});
    end
  endtask

  always @(negedge CPU_CLK) begin
    if (!CPU_RST) begin
      if (CPU_Debug_DataCache_WE2 != 0)
        handleWrite(1'b0, CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_WE2);
      if (CPU_Debug_InstCache_WE2 != 0)
        handleWrite(1'b1, CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_WE2);
      if (selCur == 1'b0 && {CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2, CPU_Debug_InstCache_WE2} != 0)
        otherPortHits++;
      if (selCur == 1'b1 && {CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2, CPU_Debug_DataCache_WE2} != 0)
        otherPortHits++;
      if (rd_valid && rd_ready) begin
        rdCyc.push_back(cyc);
        if (expRdQ.size() == 0) checkVal("rd_unexpected", rd_data, 64'hFFFF_FFFF_FFFF_FFFF);
        else checkVal("rd_data", rd_data, expRdQ.pop_front());
      end
      if (prevStall) begin
        if (!rd_valid || rd_data != prevRdData ||
            (selCur ? CPU_Debug_InstCache_A2 : CPU_Debug_DataCache_A2) != prevA2)
          stallViol++;
      end
      if (rd_valid && !rd_ready) stallCycles++;
      prevStall  = rd_valid && !rd_ready;
      prevRdData = rd_data;
      prevA2     = selCur ? CPU_Debug_InstCache_A2 : CPU_Debug_DataCache_A2;
      if (hold_core != busy || busy == cmd_ready) hcViol++;
      if (holdWindow && !hold_core) holdLow++;
      if (done) begin
        doneCount++;
        doneCyc    = cyc;
        holdWindow = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge CPU_CLK);
    #1;
  endtask

  task automatic clearStats();
    wrCyc.delete();
    rdCyc.delete();
    wrCount = 0; otherPortHits = 0; stallViol = 0; stallCycles = 0; holdLow = 0;
  endtask

  task automatic issueCmd(input logic op, input logic sel, input int base, input int count);
    int b = 0;
    while (!cmd_ready && b < 100) begin tick(); b++; end
    if (!cmd_ready) checkVal("cmd_ready_timeout", 0, 1);
    selCur    = sel;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sel   = sel;
    cmd_base  = base[IDX_W-1:0];
    cmd_count = count[IDX_W:0];
    tick();
    acceptCyc = cyc;
    // Junk on the command bus while busy must be ignored.
    cmd_valid = 1'b0;
    cmd_op    = ~op;
    cmd_base  = IDX_W'($urandom);
    cmd_count = (IDX_W+1)'($urandom);
    checkVal("busy_rise", {busy, hold_core, cmd_ready}, 3'b110);
    holdWindow = 1'b1;
  endtask

  task automatic loadWords(input logic sel, input int base, input int nWords, input bit gaps, input bit counting);
    int b;
    int idx;
    logic [31:0] d;
    for (int i = 0; i < nWords; i++) begin
      idx = (base + i) % BRAM_WORDS;
      d   = counting ? 32'(i + 1) * 32'h1111_1111 : $urandom;
      if (sel) refInst[idx] = d; else refData[idx] = d;
      expWrQ.push_back({sel, 32'(idx * 4), d});
      if (gaps) begin
        wr_valid = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
      wr_valid = 1'b1;
      wr_data  = d;
      b = 0;
      while (!wr_ready && b < 50) begin tick(); b++; end
      if (!wr_ready) checkVal("wr_ready_timeout", 0, 1);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic waitDone(input int startDone, input int budget);
    int b = 0;
    while (doneCount == startDone && b < budget) begin tick(); b++; end
    if (doneCount == startDone) checkVal("done_timeout", 0, 1);
    else begin
      checkVal("idle_after_done", cyc - doneCyc, 1);
      checkVal("idle_flags", {cmd_ready, busy, hold_core}, 3'b100);
    end
  endtask

  task automatic dumpWords(input logic sel, input int base, input int count, input int stallWord);
    int b;
    int idx;
    for (int i = 0; i < count; i++) begin
      idx = (base + i) % BRAM_WORDS;
      expRdQ.push_back(sel ? refInst[idx] : refData[idx]);
    end
    rd_ready = 1'b1;
    issueCmd(1'b1, sel, base, count);
    if (stallWord >= 0) begin
      b = 0;
      while (rdCyc.size() < stallWord && b < 100) begin tick(); b++; end
      rd_ready = 1'b0;
      repeat (10) tick();
      rd_ready = 1'b1;
    end
  endtask

  task automatic checkResetOutputs();
    checkVal("rst_ctrl", {cmd_ready, wr_ready, rd_valid, busy, done, hold_core}, 6'b100000);
    checkVal("rst_data_port", {CPU_Debug_DataCache_A2, CPU_Debug_DataCache_WD2}, 64'h0);
    checkVal("rst_inst_port", {CPU_Debug_InstCache_A2, CPU_Debug_InstCache_WD2}, 64'h0);
    checkVal("rst_we_rd", {CPU_Debug_DataCache_WE2, CPU_Debug_InstCache_WE2, rd_data}, 40'h0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  int d0;

  initial begin
    CPU_RST = 1'b1;
    cmd_valid = 1'b0; cmd_op = 1'b0; cmd_sel = 1'b0; cmd_base = '0; cmd_count = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    #1;
    checkResetOutputs();
    tick(); tick();
    CPU_RST = 1'b0;
    tick();

    // Load, base 0, four counting words to the DataCache.
    clearStats();
    d0 = doneCount;
    issueCmd(1'b0, 1'b0, 0, 4);
    loadWords(1'b0, 0, 4, 1'b0, 1'b1);
    waitDone(d0, 50);
    checkVal("t1_writes", wrCount, 4);
    checkVal("t1_other_port", otherPortHits, 0);
    checkVal("t1_done_pulses", doneCount - d0, 1);
    checkVal("t1_first_we_latency_ge2", (wrCyc[0] - acceptCyc + 1) >= 2, 1);
    for (int i = 1; i < 4; i++) checkVal("t1_load_spacing", wrCyc[i] - wrCyc[i-1], 2);
    checkVal("t1_done_latency", doneCyc - wrCyc[3], 1);

    // Dump readback of the same four words.
    clearStats();
    d0 = doneCount;
    dumpWords(1'b0, 0, 4, -1);
    waitDone(d0, 50);
    checkVal("t2_reads", rdCyc.size(), 4);
    checkVal("t2_rd_left", expRdQ.size(), 0);
    checkVal("t2_done_pulses", doneCount - d0, 1);
    for (int i = 1; i < 4; i++) checkVal("t2_dump_spacing", rdCyc[i] - rdCyc[i-1], 3);
    checkVal("t2_done_latency", doneCyc - rdCyc[3], 1);
    checkVal("t2_writes", wrCount, 0);

    // Wrap-around past the top word.
    clearStats();
    d0 = doneCount;
    issueCmd(1'b0, 1'b0, 4094, 3);
    loadWords(1'b0, 4094, 3, 1'b0, 1'b0);
    waitDone(d0, 50);
    checkVal("t3_writes", wrCount, 3);
    checkVal("t3_last_addr", lastWrAddr, 32'h0);
    d0 = doneCount;
    dumpWords(1'b0, 4094, 3, -1);
    waitDone(d0, 50);
    checkVal("t3_reads", rdCyc.size(), 3);

    // Back-pressure on word 2.
    clearStats();
    d0 = doneCount;
    dumpWords(1'b0, 0, 4, 1);
    waitDone(d0, 100);
    checkVal("t4_stall_seen", stallCycles >= 5, 1);
    checkVal("t4_stall_stable", stallViol, 0);
    checkVal("t4_reads", rdCyc.size(), 4);
    checkVal("t4_done_pulses", doneCount - d0, 1);

    // Full InstCache load with random host gaps.
    clearStats();
    d0 = doneCount;
    issueCmd(1'b0, 1'b1, 0, 0);
    loadWords(1'b1, 0, BRAM_WORDS, 1'b1, 1'b0);
    waitDone(d0, 100);
    checkVal("t5_writes", wrCount, BRAM_WORDS);
    checkVal("t5_last_addr", lastWrAddr, 32'h3FFC);
    checkVal("t5_hold_low", holdLow, 0);
    checkVal("t5_other_port", otherPortHits, 0);
    checkVal("t5_done_pulses", doneCount - d0, 1);
    clearStats();
    d0 = doneCount;
    dumpWords(1'b1, 4094, 4, -1);
    waitDone(d0, 50);
    checkVal("t5_reads", rdCyc.size(), 4);

    // Reset in the middle of an 8-word load.
    clearStats();
    d0 = doneCount;
    issueCmd(1'b0, 1'b0, 100, 8);
    loadWords(1'b0, 100, 2, 1'b0, 1'b0);
    tick();
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    tick();
    CPU_RST = 1'b1;
    #1;
    checkResetOutputs();
    wr_valid = 1'b0;
    tick(); tick();
    CPU_RST = 1'b0;
    tick();
    checkVal("t6_writes", wrCount, 2);
    checkVal("t6_no_done", doneCount - d0, 0);
    checkVal("t6_exp_left", expWrQ.size(), 0);
    d0 = doneCount;
    dumpWords(1'b0, 100, 2, -1);
    waitDone(d0, 50);
    checkVal("t6_reads_after_reset", rdCyc.size(), 2);

    checkVal("hold_eq_busy", hcViol, 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
